s2p: RTL and testbench
======================

// Module: s2p
// PURPOSE
//   Serial-to-parallel deserializer, the receive-side counterpart of the team's p2s block.
//   Accepts one bit per cycle over a valid/ready serial interface and assembles NUM-bit words.
//   Presents each word on a valid/ready parallel interface through a one-word output holding register.
//   Bit collection for the next word overlaps with a pending output word.
// PARAMETERS
//   NUM        8   word width in bits (>= 2); bit counter width is $clog2(NUM)
//   MSB_FIRST  0   0: first received bit -> p_data[0] (LSB-first, matches p2s); 1: first bit -> p_data[NUM-1]
// PORTS
//   clk      in   1    single clock, all logic on posedge
//   rst      in   1    synchronous reset, active-high
//   s_data   in   1    serial data bit
//   s_valid  in   1    s_data is valid this cycle
//   s_ready  out  1    block accepts s_data this cycle
//   p_data   out  NUM  assembled word, registered
//   p_valid  out  1    p_data holds a complete word
//   p_ready  in   1    downstream accepts p_data this cycle
// BEHAVIOUR
//   - Reset (rst=1 at posedge): count=0, shift_reg=0, p_data=0, p_valid=0. s_ready=0 while rst is high.
//   - Serial accept: s_valid && s_ready at posedge. Parallel handshake: p_valid && p_ready at posedge.
//   - Gaps in s_valid are allowed; count and shift_reg hold. Bits are never dropped or duplicated.
//   - Collection: on each serial accept with count < NUM-1, the bit is shifted into shift_reg and count increments.
//       MSB_FIRST=0: shift right, insert at bit NUM-1. MSB_FIRST=1: shift left, insert at bit 0.
//   - Completion: a serial accept with count == NUM-1 does the following at that edge:
//       p_data <= the full word including this bit; p_valid <= 1; count <= 0.
//     The shift_reg contents after completion are don't-care.
//   - Latency: p_valid is high the cycle after the NUM-th bit is accepted.
//   - Output register states:
//       EMPTY (p_valid=0) -> HOLD on completion.
//       HOLD -> EMPTY on parallel handshake without completion in the same cycle.
//       HOLD -> HOLD with new p_data when a handshake and a completion occur in the same cycle.
//   - Stability: while p_valid && !p_ready, p_data and p_valid hold unchanged.
//   - Backpressure: s_ready = !rst && !(count == NUM-1 && p_valid && !p_ready).
//       Collection proceeds up to NUM-1 bits while a word is pending.
//       Only the completing bit stalls on a pending word.
//       s_ready depends combinationally on p_ready. No combinational path from s_valid to s_ready.
//   - Throughput: with p_ready held at 1 and s_valid held at 1, one word is produced every NUM cycles with no stall cycles.
//   - Reset mid-word or with a word pending: the partial word and the pending word are discarded.
//     Collection restarts at count=0.
//   - No combinational path from s_data or s_valid to p_data or p_valid.
// TESTING
//   1. Hold rst=1 for 2 cycles -> s_ready=0, p_valid=0, p_data=0. After release: s_ready=1.
//   2. MSB_FIRST=0, p_ready=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles
//      -> p_data=8'hA5 and p_valid=1 for exactly 1 cycle, the cycle after the 8th bit.
//   3. p_ready=0. Send 0x3C, then 0x81 -> 0x3C is held; s_ready=0 after 7 bits of 0x81.
//      Raise p_ready -> the handshake of 0x3C and the acceptance of the 8th bit occur on the same edge.
//      The next cycle shows p_data=8'h81 with p_valid=1.
//   4. Send 0x5A with random 0-3 cycle s_valid gaps -> p_data=8'h5A; exactly one word is produced.
//   5. Send 4 bits, then pulse rst, then send 8 bits of 0xC3 -> only 0xC3 appears; the partial bits are discarded.
//   6. MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 -> p_data=8'hA5. Connect p2s output to s2p input -> words round-trip unchanged.

Source files
------------

// File: rtl/s2p.sv
// Serial-to-parallel deserializer: collects NUM serial bits per word and presents
// each word through a one-word holding register, overlapping collection of the next word.
module s2p #(
    parameter int NUM       = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_data,
    input  logic           s_valid,
    output logic           s_ready,
    output logic [NUM-1:0] p_data,
    output logic           p_valid,
    input  logic           p_ready
);
    localparam int             CW   = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CW-1:0]  LAST = CW'(NUM - 1);

    logic [CW-1:0]  count;
    logic [NUM-1:0] shift_reg;
    logic [NUM-1:0] shift_nxt;
    logic           last;
    logic           s_acc;
    logic           done;
    logic           p_hs;

    assign last  = (count == LAST);
    // Only the completing bit waits for the holding register to free up.
    assign s_ready = !rst && !(last && p_valid && !p_ready);
    assign s_acc   = s_valid && s_ready;
    assign done    = s_acc && last;
    assign p_hs    = p_valid && p_ready;

    // On the completing bit the shifted value is exactly the finished word.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shift_nxt = {shift_reg[NUM-2:0], s_data};
        end else begin : g_lsb
            assign shift_nxt = {s_data, shift_reg[NUM-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            shift_reg <= '0;
            p_data    <= '0;
            p_valid   <= 1'b0;
        end else begin
            if (s_acc) begin
                shift_reg <= shift_nxt;
                count     <= last ? '0 : count + 1'b1;
            end
            if (done) begin
                p_data  <= shift_nxt;
                p_valid <= 1'b1;
            end else if (p_hs) begin
                p_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_s2p.sv
// Directed self-checking bench for s2p: LSB-first and MSB-first instances share the serial stream.
module tb_s2p;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_data = 1'b0;
    logic       s_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic       s_ready, s_ready_m;
    logic [7:0] p_data, p_data_m;
    logic       p_valid, p_valid_m;

    int errors = 0;
    int checks = 0;
    logic [7:0] q[$];

    s2p #(.NUM(8), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready)
    );

    s2p #(.NUM(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_m),
        .p_data(p_data_m), .p_valid(p_valid_m), .p_ready(p_ready)
    );

    always #5 clk = ~clk;

    // Record every parallel handshake on the LSB-first instance.
    always @(posedge clk)
        if (!rst && p_valid && p_ready) q.push_back(p_data);

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; p_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL reset_p_valid got=%b exp=0", p_valid); end
        checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data got=%h exp=00", p_data); end
        checks++; if (p_valid_m !== 1'b0 || p_data_m !== 8'h00) begin errors++; $display("FAIL reset_msb got=%b/%h exp=0/00", p_valid_m, p_data_m); end
        rst = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL release_s_ready got=%b exp=1", s_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] bits;
        bits = 8'b1010_0101;
        p_ready = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = bits[7-i];
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL basic_s_ready bit=%0d got=%b exp=1", i, s_ready); end
            if (i == 7) begin
                checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", p_valid); end
            end
            @(posedge clk); @(negedge clk);
        end
        s_valid = 1'b0;
        checks++; if (p_valid !== 1'b1 || p_data !== 8'hA5) begin errors++; $display("FAIL basic_word got=%b/%h exp=1/a5", p_valid, p_data); end
        checks++; if (p_valid_m !== 1'b1 || p_data_m !== 8'hA5) begin errors++; $display("FAIL msb_word got=%b/%h exp=1/a5", p_valid_m, p_data_m); end
        @(posedge clk); @(negedge clk);
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got=%b exp=0", p_valid); end
        checks++; if (q.size() != 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", q.size()); end
    endtask

    task automatic test_backpressure();
        logic [7:0] w0, w1;
        w0 = 8'h3C; w1 = 8'h81;
        p_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = w0[i];
            @(posedge clk); @(negedge clk);
        end
        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1; s_data = w1[i];
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_collect bit=%0d got=%b exp=1", i, s_ready); end
            @(posedge clk); @(negedge clk);
        end
        s_valid = 1'b1; s_data = w1[7];
        for (int c = 0; c < 2; c++) begin
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_stall cyc=%0d got=%b exp=0", c, s_ready); end
            checks++; if (p_valid !== 1'b1 || p_data !== 8'h3C) begin errors++; $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/3c", c, p_valid, p_data); end
            @(posedge clk); @(negedge clk);
        end
        p_ready = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", s_ready); end
        @(posedge clk); @(negedge clk);
        s_valid = 1'b0;
        checks++; if (p_valid !== 1'b1 || p_data !== 8'h81) begin errors++; $display("FAIL bp_next_word got=%b/%h exp=1/81", p_valid, p_data); end
        checks++; if (q.size() != 1 || q[0] !== 8'h3C) begin errors++; $display("FAIL bp_first_hs got=%0d exp=1 word 3c", q.size()); end
        @(posedge clk); @(negedge clk);
        checks++; if (p_valid !== 1'b0 || q.size() != 2) begin errors++; $display("FAIL bp_drain got=%b/%0d exp=0/2", p_valid, q.size()); end
        else begin
            checks++; if (q[1] !== 8'h81) begin errors++; $display("FAIL bp_second_hs got=%h exp=81", q[1]); end
        end
    endtask

    task automatic test_gaps();
        logic [7:0] w;
        int g;
        w = 8'h5A;
        p_ready = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) begin
            g = $urandom_range(0, 3);
            s_valid = 1'b0;
            repeat (g) begin @(posedge clk); @(negedge clk); end
            s_valid = 1'b1; s_data = w[i];
            @(posedge clk); @(negedge clk);
        end
        s_valid = 1'b0;
        repeat (4) begin @(posedge clk); @(negedge clk); end
        checks++; if (q.size() != 1) begin errors++; $display("FAIL gaps_count got=%0d exp=1", q.size()); end
        else begin
            checks++; if (q[0] !== 8'h5A) begin errors++; $display("FAIL gaps_word got=%h exp=5a", q[0]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        w = 8'hC3;
        // A pending word must be discarded by reset.
        p_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin s_valid = 1'b1; s_data = 1'b1; @(posedge clk); @(negedge clk); end
        for (int i = 0; i < 4; i++) begin s_valid = 1'b1; s_data = 1'b1; @(posedge clk); @(negedge clk); end
        s_valid = 1'b0; rst = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rstmid_s_ready got=%b exp=0", s_ready); end
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        checks++; if (p_valid !== 1'b0 || p_data !== 8'h00) begin errors++; $display("FAIL rstmid_pending got=%b/%h exp=0/00", p_valid, p_data); end
        p_ready = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) begin s_valid = 1'b1; s_data = w[i]; @(posedge clk); @(negedge clk); end
        s_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        checks++; if (q.size() != 1) begin errors++; $display("FAIL rstmid_count got=%0d exp=1", q.size()); end
        else begin
            checks++; if (q[0] !== 8'hC3) begin errors++; $display("FAIL rstmid_word got=%h exp=c3", q[0]); end
        end
    endtask

    task automatic test_msb_roundtrip();
        logic [7:0] words [5];
        logic [7:0] w;
        words = '{8'h1E, 8'h00, 8'hFF, 8'h12, 8'hC7};
        p_ready = 1'b1;
        q.delete();
        // Serializer model streams LSB-first words back to back with s_valid held high.
        for (int k = 0; k < 5; k++) begin
            w = words[k];
            for (int i = 0; i < 8; i++) begin
                s_valid = 1'b1; s_data = w[i];
                checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rt_stall word=%0d bit=%0d got=%b exp=1", k, i, s_ready); end
                if (i == 0 && k == 1) begin
                    checks++; if (p_valid_m !== 1'b1 || p_data_m !== 8'h78) begin errors++; $display("FAIL msb_reverse got=%b/%h exp=1/78", p_valid_m, p_data_m); end
                end
                if (i == 0 && k > 0) begin
                    checks++; if (p_valid !== 1'b1 || p_data !== words[k-1]) begin errors++; $display("FAIL rt_cadence word=%0d got=%b/%h exp=1/%h", k-1, p_valid, p_data, words[k-1]); end
                end
                @(posedge clk); @(negedge clk);
            end
        end
        s_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (q.size() != 5) begin errors++; $display("FAIL rt_count got=%0d exp=5", q.size()); end
        else begin
            for (int k = 0; k < 5; k++) begin
                checks++; if (q[k] !== words[k]) begin errors++; $display("FAIL rt_word idx=%0d got=%h exp=%h", k, q[k], words[k]); end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_msb_roundtrip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
